dmx_pry: RTL and testbench

Demultiplexer with priority select: the transmit-side counterpart of the priority multiplexer. It takes a single valid/ready data stream and routes each beat to exactly one of `WIDTH` output channels. The channel is the highest-index bit set in the `pry` vector sampled with the beat. One registered output stage decouples the timing. Beats presented with an empty `pry` are dropped and counted. The block sits in front of arrays of consumers where the mux_pry gathers their results back.

---
 rtl/dmx_pry.sv | 137 +++++++++++++
 tb/tb_dmx_pry.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dmx_pry.sv
// dmx_pry: priority-select demultiplexer.
// Routes each accepted beat of one valid/ready stream to the highest-index
// channel requested in pry, through a single registered output stage.
// Beats arriving with an empty request vector are dropped and counted.
module dmx_pry #(
   parameter type DAT_T          = logic [8-1:0],
   parameter int  WIDTH          = 9,
   parameter int  SPLIT          = 3,
   parameter int  IMPLEMENTATION = 0,
   parameter int  CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_vld,
   output logic             s_rdy,
   input  DAT_T             s_dat,
   input  logic [WIDTH-1:0] pry,
   output logic [WIDTH-1:0] m_vld,
   input  logic [WIDTH-1:0] m_rdy,
   output DAT_T             m_dat,
   output logic [CNT_W-1:0] drp_cnt
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // Number of SPLIT-ary reduction levels needed to fold WIDTH leaves to one.
   function automatic int tree_levels(int w, int s);
      int n;
      int l;
      n = w;
      l = 0;
      for (int k = 0; k < 32; k++) begin
         if (n > 1) begin
            n = (n + s - 1) / s;
            l++;
         end
      end
      return l;
   endfunction

   localparam int LVLS = tree_levels(WIDTH, SPLIT);

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   logic             state;
   logic [WIDTH-1:0] sel;
   logic [IDX_W-1:0] dst_idx;
   logic [WIDTH-1:0] dst_oh;
   logic             pry_any;
   logic             out_xfer;
   logic             in_xfer;

   generate
      if (IMPLEMENTATION == 0) begin : g_linear
         // Linear scan upwards: the last set bit seen is the highest, so it wins.
         // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
         always_comb begin
            dst_idx = '0;
            for (int i = 0; i < WIDTH; i++) begin
               if (pry[i]) dst_idx = IDX_W'(i);
            end
         end
      end else begin : g_tree
         // SPLIT-ary tree: each node forwards the index of its highest valid child.
         always_comb begin : tree_enc
            logic [WIDTH-1:0] t_vld [LVLS+1];
            logic [IDX_W-1:0] t_idx [LVLS+1][WIDTH];
            int               n;
            int               k;
            for (int l = 0; l <= LVLS; l++) begin
               t_vld[l] = '0;
               for (int j = 0; j < WIDTH; j++) t_idx[l][j] = '0;
            end
            t_vld[0] = pry;
            for (int j = 0; j < WIDTH; j++) t_idx[0][j] = IDX_W'(j);
            n = WIDTH;
            k = 0;
            for (int l = 0; l < LVLS; l++) begin
               for (int g = 0; g < WIDTH; g++) begin
                  for (int c = 0; c < SPLIT; c++) begin
                     k = g * SPLIT + c;
                     if (k < n) begin
                        if (t_vld[l][k]) begin
                           t_vld[l+1][g] = 1'b1;
                           t_idx[l+1][g] = t_idx[l][k];
                        end
                     end
                  end
               end
               n = (n + SPLIT - 1) / SPLIT;
            end
            dst_idx = t_idx[LVLS][0];
         end
      end
   endgenerate

   // Expand the winning index into the one-hot channel select.
   always_comb begin
      dst_oh = '0;
      for (int i = 0; i < WIDTH; i++) begin
         dst_oh[i] = (dst_idx == IDX_W'(i));
      end
   end

   assign pry_any  = |pry;
   assign out_xfer = (state == ST_FULL) && (|(sel & m_rdy));
   // Reset forces ready high; the register update below still ignores the beat.
   assign s_rdy    = rst || (state == ST_EMPTY) || (|(sel & m_rdy));
   assign in_xfer  = s_vld && s_rdy;
   assign m_vld    = (state == ST_FULL) ? sel : '0;

   // Output stage: load, drain or drop, with the saturating drop counter.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_EMPTY;
         sel     <= '0;
         m_dat   <= '0;
         drp_cnt <= '0;
      end else if (in_xfer) begin
         if (pry_any) begin
            state <= ST_FULL;
            sel   <= dst_oh;
            m_dat <= s_dat;
         end else begin
            state <= ST_EMPTY;
            sel   <= '0;
            if (drp_cnt != '1) drp_cnt <= drp_cnt + CNT_W'(1);
         end
      end else if (out_xfer) begin
         state <= ST_EMPTY;
         sel   <= '0;
      end
   end

endmodule

// File: tb/tb_dmx_pry.sv
// tb_dmx_pry: checks dmx_pry (linear encoder, tree encoder, and a 2-bit drop
// counter variant) against a transaction-level model of the routing rules.
module tb_dmx_pry;

   localparam int W = 9;

   logic         clk = 1'b0;
   logic         rst;
   logic         s_vld;
   logic [7:0]   s_dat;
   logic [W-1:0] pry;
   logic [W-1:0] m_rdy;

   logic         s_rdy0, s_rdy1, s_rdy2;
   logic [W-1:0] m_vld0, m_vld1, m_vld2;
   logic [7:0]   m_dat0, m_dat1, m_dat2;
   logic [7:0]   drp0, drp1;
   logic [1:0]   drp2;

   int checks = 0;
   int errors = 0;

   // Reference model: one pending slot, its destination and data, and a drop tally.
   bit         mf;
   int         mdest;
   logic [7:0] mdat;
   int         mdrop;

   dmx_pry #(.WIDTH(W), .SPLIT(3), .IMPLEMENTATION(0), .CNT_W(8)) u_lin (
      .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(s_rdy0), .s_dat(s_dat), .pry(pry),
      .m_vld(m_vld0), .m_rdy(m_rdy), .m_dat(m_dat0), .drp_cnt(drp0));

   dmx_pry #(.WIDTH(W), .SPLIT(3), .IMPLEMENTATION(1), .CNT_W(8)) u_tree (
      .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(s_rdy1), .s_dat(s_dat), .pry(pry),
      .m_vld(m_vld1), .m_rdy(m_rdy), .m_dat(m_dat1), .drp_cnt(drp1));

   dmx_pry #(.WIDTH(W), .SPLIT(3), .IMPLEMENTATION(0), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(s_rdy2), .s_dat(s_dat), .pry(pry),
      .m_vld(m_vld2), .m_rdy(m_rdy), .m_dat(m_dat2), .drp_cnt(drp2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Highest requested channel, or -1 when nothing is requested.
   function automatic int top_bit(input logic [W-1:0] p);
      for (int i = W - 1; i >= 0; i--) begin
         if (p[i] === 1'b1) return i;
      end
      return -1;
   endfunction

   // Compare all instances mid-cycle, then advance the model across the edge.
   task automatic cycle();
      logic [W-1:0] ev;
      logic [31:0]  ed8;
      logic [31:0]  ed2;
      bit           er;
      int           d;
      @(negedge clk);
      ev  = mf ? (W'(1) << mdest) : '0;
      er  = rst || !mf || (m_rdy[mdest] === 1'b1);
      ed8 = (mdrop > 255) ? 32'd255 : 32'(mdrop);
      ed2 = (mdrop > 3) ? 32'd3 : 32'(mdrop);
      check("lin_vld",  32'(m_vld0), 32'(ev));
      check("lin_dat",  32'(m_dat0), 32'(mdat));
      check("lin_rdy",  32'(s_rdy0), 32'(er));
      check("lin_drp",  32'(drp0),   ed8);
      check("tree_vld", 32'(m_vld1), 32'(ev));
      check("tree_dat", 32'(m_dat1), 32'(mdat));
      check("tree_rdy", 32'(s_rdy1), 32'(er));
      check("tree_drp", 32'(drp1),   ed8);
      check("sat_vld",  32'(m_vld2), 32'(ev));
      check("sat_rdy",  32'(s_rdy2), 32'(er));
      check("sat_drp",  32'(drp2),   ed2);
      d = top_bit(pry);
      if (rst) begin
         mf    = 1'b0;
         mdat  = '0;
         mdrop = 0;
      end else if (s_vld && er) begin
         if (d < 0) begin
            mf = 1'b0;
            mdrop++;
         end else begin
            mf    = 1'b1;
            mdest = d;
            mdat  = s_dat;
         end
      end else if (mf && m_rdy[mdest]) begin
         mf = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic v, input logic [7:0] d, input logic [W-1:0] p,
                       input logic [W-1:0] r);
      s_vld = v;
      s_dat = d;
      pry   = p;
      m_rdy = r;
      cycle();
   endtask

   initial begin
      rst   = 1'b1;
      s_vld = 1'b0;
      s_dat = '0;
      pry   = '0;
      m_rdy = '1;
      mf    = 1'b0;
      mdest = 0;
      mdat  = '0;
      mdrop = 0;
      @(posedge clk);
      #1;
      cycle();
      rst = 1'b0;
      check("rst_vld", 32'(m_vld0), 32'd0);
      check("rst_rdy", 32'(s_rdy0), 32'd1);

      // One-hot routing to every channel.
      for (int i = 0; i < W; i++) begin
         beat(1'b1, 8'(i), W'(1) << i, '1);
         check("route_vld", 32'(m_vld0), 32'(W'(1) << i));
         check("route_dat", 32'(m_dat0), 32'(i));
      end

      // Several request bits set: highest wins.
      beat(1'b1, 8'hA5, 9'b0_0001_0110, '1);
      check("pri_vld", 32'(m_vld0), 32'h010);
      check("pri_dat", 32'(m_dat0), 32'hA5);
      beat(1'b1, 8'h3C, 9'h1FF, '1);
      check("pri_all", 32'(m_vld1), 32'h100);
      beat(1'b0, 8'h00, '0, '1);

      // Backpressure on channel 2 while a beat for channel 5 waits.
      beat(1'b1, 8'h22, W'(1) << 2, '1);
      for (int i = 0; i < 3; i++) begin
         beat(1'b1, 8'h55, W'(1) << 5, 9'h1FB);
         check("bp_rdy", 32'(s_rdy0), 32'd0);
         check("bp_vld", 32'(m_vld0), 32'h004);
         check("bp_dat", 32'(m_dat0), 32'h22);
      end
      beat(1'b1, 8'h55, W'(1) << 5, '1);
      check("hand_vld", 32'(m_vld0), 32'h020);
      check("hand_dat", 32'(m_dat0), 32'h55);

      // Reset while a beat is pending discards it.
      beat(1'b0, 8'h00, '0, '0);
      rst = 1'b1;
      beat(1'b1, 8'h77, W'(1) << 1, '1);
      rst = 1'b0;
      check("mrst_vld", 32'(m_vld0), 32'd0);
      check("mrst_dat", 32'(m_dat0), 32'd0);
      check("mrst_drp", 32'(drp0),   32'd0);
      check("mrst_rdy", 32'(s_rdy0), 32'd1);

      // Unknown bits below the winner must not disturb the choice.
      beat(1'b1, 8'h66, 9'b0_01xx_xxxx, '1);
      check("x_lin",  32'(m_vld0), 32'h040);
      check("x_tree", 32'(m_vld1), 32'h040);

      // Drops and counter saturation.
      for (int i = 0; i < 3; i++) beat(1'b1, 8'(i), '0, '1);
      check("drop3",     32'(drp0),   32'd3);
      check("drop3_vld", 32'(m_vld0), 32'd0);
      for (int i = 0; i < 2; i++) beat(1'b1, 8'(i), '0, '1);
      check("drop5",     32'(drp0), 32'd5);
      check("drop5_sat", 32'(drp2), 32'd3);

      // Random traffic, both encoders against the model every cycle.
      for (int n = 0; n < 1000; n++) begin
         beat(($urandom_range(0, 3) != 0),
              8'($urandom),
              ($urandom_range(0, 7) == 0) ? '0 : W'($urandom),
              W'($urandom | $urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
